nnspc_cfg_loader: RTL

//  Parametrised, fully synchronous serial configuration loader for the neuron-array SPC front end.

---
 rtl/nnspc_cfg_loader.sv | 138 +++++++++++++
 1 files changed

// File: rtl/nnspc_cfg_loader.sv
// Serial configuration loader: shifts MSB-first frames and commits each atomically to one of N_CH channels.
// Define NNSPC_PARITY_EN to append and check a trailing even-parity bit on every frame.
module nnspc_cfg_loader #(
  parameter int unsigned N_CH   = 4,
  parameter int unsigned NSEL_W = 5,
  parameter int unsigned DAC_W  = 4
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   Cfg_in,
  input  logic                   Cfg_en,
  input  logic                   Cfg_start,
  output logic [N_CH*NSEL_W-1:0] NSEL,
  output logic [N_CH*DAC_W-1:0]  DAC,
  output logic [N_CH-1:0]        RE,
  output logic                   Cfg_busy,
  output logic                   Cfg_done,
  output logic                   Cfg_err
);

  localparam int unsigned ADDR_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
`ifdef NNSPC_PARITY_EN
  localparam int unsigned PAR_W    = 1;
`else
  localparam int unsigned PAR_W    = 0;
`endif
  localparam int unsigned FRAME_W  = ADDR_W + NSEL_W + DAC_W + 1 + PAR_W;
  localparam int unsigned CNT_W    = $clog2(FRAME_W);
  localparam int unsigned RE_POS   = PAR_W;
  localparam int unsigned DAC_LSB  = PAR_W + 1;
  localparam int unsigned NSEL_LSB = DAC_LSB + DAC_W;
  localparam int unsigned ADDR_LSB = NSEL_LSB + NSEL_W;

  // The newest bit is never stored: the full frame is {shift_q, Cfg_in} on the last edge.
  logic [FRAME_W-2:0]      shift_q, shift_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [FRAME_W-1:0]      cap_q, cap_d;
  logic                    cap_vld_q, cap_vld_d;
  logic [N_CH*NSEL_W-1:0]  nsel_q, nsel_d;
  logic [N_CH*DAC_W-1:0]   dac_q, dac_d;
  logic [N_CH-1:0]         re_q, re_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  logic [FRAME_W-1:0]      frame_c;
  logic [CNT_W-1:0]        idx_c;
  logic [ADDR_W-1:0]       addr_c;
  logic                    par_ok_c;
  logic                    commit_ok_c;

  // Shift stage: accept one bit per enabled cycle, hand complete frames to the capture register.
  always_comb begin
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    cap_d     = cap_q;
    cap_vld_d = 1'b0;
    frame_c   = {shift_q, Cfg_in};
    idx_c     = Cfg_start ? '0 : cnt_q;
    if (Cfg_start) begin
      cnt_d = '0;
    end
    if (Cfg_en) begin
      shift_d = frame_c[FRAME_W-2:0];
      if (idx_c == CNT_W'(FRAME_W - 1)) begin
        cap_d     = frame_c;
        cap_vld_d = 1'b1;
        cnt_d     = '0;
      end else begin
        cnt_d = idx_c + CNT_W'(1);
      end
    end
    busy_d = (cnt_d != '0);
  end

  // Commit stage: validate the captured frame and update only the addressed channel.
  always_comb begin
    nsel_d = nsel_q;
    dac_d  = dac_q;
    re_d   = re_q;
    done_d = 1'b0;
    err_d  = 1'b0;
    addr_c = cap_q[ADDR_LSB +: ADDR_W];
`ifdef NNSPC_PARITY_EN
    par_ok_c = ~^cap_q;
`else
    par_ok_c = 1'b1;
`endif
    commit_ok_c = ({1'b0, addr_c} < (ADDR_W + 1)'(N_CH)) && par_ok_c;
    if (cap_vld_q) begin
      done_d = commit_ok_c;
      err_d  = !commit_ok_c;
      if (commit_ok_c) begin
        for (int unsigned c = 0; c < N_CH; c++) begin
          if (addr_c == ADDR_W'(c)) begin
            nsel_d[c*NSEL_W +: NSEL_W] = cap_q[NSEL_LSB +: NSEL_W];
            dac_d[c*DAC_W +: DAC_W]    = cap_q[DAC_LSB +: DAC_W];
            re_d[c]                    = cap_q[RE_POS];
          end
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      shift_q   <= '0;
      cnt_q     <= '0;
      cap_q     <= '0;
      cap_vld_q <= 1'b0;
      nsel_q    <= '0;
      dac_q     <= '0;
      re_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      cap_q     <= cap_d;
      cap_vld_q <= cap_vld_d;
      nsel_q    <= nsel_d;
      dac_q     <= dac_d;
      re_q      <= re_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign NSEL     = nsel_q;
  assign DAC      = dac_q;
  assign RE       = re_q;
  assign Cfg_busy = busy_q;
  assign Cfg_done = done_q;
  assign Cfg_err  = err_q;

endmodule
